acl_spi_responder: RTL



---
 rtl/acl_spi_responder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/acl_spi_responder.sv
// SPI mode-0 slave that mimics the accelerometer register interface: ID registers,
// snapshotted axis data and two writable control registers, all oversampled on clk.
`timescale 1ns/1ps

module acl_spi_responder #(
    parameter logic [7:0] DEVID_AD   = 8'hAD,
    parameter logic [7:0] DEVID_MST  = 8'h1D,
    parameter logic [7:0] PARTID     = 8'hF2,
    parameter logic [7:0] FILTER_RST = 8'h13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    input  logic [11:0] x_data,
    input  logic [11:0] y_data,
    input  logic [11:0] z_data,
    output logic [7:0]  filter_ctl,
    output logic [7:0]  power_ctl,
    output logic        wr_strobe,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        cmd_err
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR_W, ADDR_R, DATA_W, DATA_R, IGNORE
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;

    state_t      state_q, state_d;
    logic [2:0]  sclk_sync, cs_sync;
    logic [1:0]  mosi_sync;
    logic        sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_bit;
    logic        bit_active, byte_done;
    logic [2:0]  bit_cnt;
    logic [6:0]  shift_q;
    logic [7:0]  rx_byte;
    logic [5:0]  addr_q, addr_next;
    logic [7:0]  tx_q, rd_data;
    logic [11:0] x_sh, y_sh, z_sh;
    logic        load_tx, write_fire, cmd_bad;

    // NOTE: synchronizer flops are deliberately not reset: they keep tracking the pins
    // through reset, so releasing rst mid-transaction cannot fabricate a CS edge.
    always_ff @(posedge clk) begin
        sclk_sync <= {sclk_sync[1:0], sclk};
        cs_sync   <= {cs_sync[1:0], cs};
        mosi_sync <= {mosi_sync[0], mosi};
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];
    assign mosi_bit  = mosi_sync[1];

    // A CS rise implies cs_sync[1]=1, so it always beats a coincident SCLK rise.
    assign bit_active = sclk_rise && !cs_sync[1] && (state_q != IDLE);
    assign byte_done  = bit_active && (bit_cnt == 3'd7);
    assign rx_byte    = {shift_q, mosi_bit};

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (cs_fall) state_d = CMD;
                CMD:     if (byte_done) begin
                             if (rx_byte == CMD_WRITE)     state_d = ADDR_W;
                             else if (rx_byte == CMD_READ) state_d = ADDR_R;
                             else                          state_d = IGNORE;
                         end
                ADDR_W:  if (byte_done) state_d = DATA_W;
                ADDR_R:  if (byte_done) state_d = DATA_R;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        load_tx    = 1'b0;
        write_fire = 1'b0;
        cmd_bad    = 1'b0;
        addr_next  = addr_q;
        if (byte_done) begin
            case (state_q)
                CMD:    cmd_bad = (rx_byte != CMD_WRITE) && (rx_byte != CMD_READ);
                ADDR_W: addr_next = rx_byte[5:0];
                ADDR_R: begin
                    addr_next = rx_byte[5:0];
                    load_tx   = 1'b1;
                end
                DATA_W: begin
                    write_fire = 1'b1;
                    addr_next  = addr_q + 6'd1;
                end
                DATA_R: begin
                    load_tx   = 1'b1;
                    addr_next = addr_q + 6'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (addr_next)
            6'h00: rd_data = DEVID_AD;
            6'h01: rd_data = DEVID_MST;
            6'h02: rd_data = PARTID;
            6'h08: rd_data = x_sh[11:4];
            6'h09: rd_data = y_sh[11:4];
            6'h0A: rd_data = z_sh[11:4];
            6'h0E: rd_data = x_sh[7:0];
            6'h0F: rd_data = {{4{x_sh[11]}}, x_sh[11:8]};
            6'h10: rd_data = y_sh[7:0];
            6'h11: rd_data = {{4{y_sh[11]}}, y_sh[11:8]};
            6'h12: rd_data = z_sh[7:0];
            6'h13: rd_data = {{4{z_sh[11]}}, z_sh[11:8]};
            6'h2C: rd_data = filter_ctl;
            6'h2D: rd_data = power_ctl;
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            miso       <= 1'b0;
            filter_ctl <= FILTER_RST;
            power_ctl  <= 8'h00;
            wr_strobe  <= 1'b0;
            wr_addr    <= 6'h00;
            wr_data    <= 8'h00;
            cmd_err    <= 1'b0;
            bit_cnt    <= 3'd0;
            shift_q    <= 7'h00;
            addr_q     <= 6'h00;
            tx_q       <= 8'h00;
            x_sh       <= 12'h000;
            y_sh       <= 12'h000;
            z_sh       <= 12'h000;
        end else begin
            wr_strobe <= 1'b0;
            cmd_err   <= cmd_bad;
            addr_q    <= addr_next;

            if (cs_fall) begin
                x_sh <= x_data;
                y_sh <= y_data;
                z_sh <= z_data;
            end

            if (cs_rise || cs_fall) begin
                bit_cnt <= 3'd0;
            end else if (bit_active) begin
                bit_cnt <= bit_cnt + 3'd1;
                shift_q <= rx_byte[6:0];
            end

            if (write_fire) begin
                wr_strobe <= 1'b1;
                wr_addr   <= addr_q;
                wr_data   <= rx_byte;
                if (addr_q == 6'h2C) filter_ctl <= rx_byte;
                if (addr_q == 6'h2D) power_ctl  <= rx_byte;
            end

            // A fall right after a byte-completing rise sees bit_cnt=0 and re-drives tx[7].
            if (cs_rise) begin
                miso <= 1'b0;
            end else if (load_tx) begin
                tx_q <= rd_data;
                miso <= rd_data[7];
            end else if (state_q == DATA_R) begin
                if (sclk_fall) miso <= tx_q[3'd7 - bit_cnt];
            end else begin
                miso <= 1'b0;
            end
        end
    end

endmodule
